gcd_dispatch: RTL

GCD_DISPATCH -- requirements
Module: gcd_dispatch

---
 rtl/gcd_dispatch_if.sv | 36 +++
 rtl/gcd_dispatch.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/gcd_dispatch_if.sv
// Handshake bundle for gcd_dispatch: upstream operand stream, GCD core link,
// and downstream result stream. slave is the dispatcher's view, master the environment's.
interface gcd_dispatch_if #(
    parameter int W = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;

    logic [W-1:0] core_a;
    logic [W-1:0] core_b;
    logic         core_start;
    logic [W-1:0] core_q;
    logic         core_done;

    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_q;
    logic [W-1:0] out_a;
    logic [W-1:0] out_b;
    logic         out_err;
    logic         busy;

    modport slave (
        input  in_valid, in_a, in_b, core_q, core_done, out_ready,
        output in_ready, core_a, core_b, core_start,
               out_valid, out_q, out_a, out_b, out_err, busy
    );

    modport master (
        output in_valid, in_a, in_b, core_q, core_done, out_ready,
        input  in_ready, core_a, core_b, core_start,
               out_valid, out_q, out_a, out_b, out_err, busy
    );
endinterface

// File: rtl/gcd_dispatch.sv
// Operand FIFO feeding an external GCD core one pair at a time, with zero-operand
// bypass, a WAIT timeout and a held result stage.
//
// state | meaning
// IDLE  | waiting for a queued pair; pops the head when one is present
// ISSUE | core_start pulse, timeout counter cleared
// WAIT  | waiting for core_done or timeout
// HOLD  | result presented on out_*, released by out_ready
module gcd_dispatch #(
    parameter int W       = 4,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input logic          clk,
    input logic          rst,
    gcd_dispatch_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TC = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    logic [W-1:0]  r_mem_a [DEPTH];
    logic [W-1:0]  r_mem_b [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    state_t        r_state;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_q;
    logic          r_err;
    logic          r_start;
    logic          r_valid;
    logic          r_busy;
    logic [CW-1:0] r_cnt;

    logic          w_in_ready;
    logic          w_push;
    logic          w_pop;
    logic [W-1:0]  w_head_a;
    logic [W-1:0]  w_head_b;

    // Pop only sees the registered count, so a pair pushed at an edge is poppable from the next one.
    assign w_in_ready = (r_count < (AW+1)'(DEPTH));
    assign w_push     = bus.in_valid && w_in_ready;
    assign w_pop      = (r_state == IDLE) && (r_count != '0);
    assign w_head_a   = r_mem_a[r_rptr];
    assign w_head_b   = r_mem_b[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wptr] <= bus.in_a;
            r_mem_b[r_wptr] <= bus.in_b;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_q     <= '0;
            r_err   <= 1'b0;
            r_start <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_a    <= w_head_a;
                        r_b    <= w_head_b;
                        r_busy <= 1'b1;
                        if (w_head_a == '0 || w_head_b == '0) begin
                            r_q     <= w_head_a | w_head_b;
                            r_err   <= 1'b0;
                            r_valid <= 1'b1;
                            r_state <= HOLD;
                        end else begin
                            r_start <= 1'b1;
                            r_state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    // core_done is tested first so it wins over a coincident timeout.
                    if (bus.core_done) begin
                        r_q     <= bus.core_q;
                        r_err   <= 1'b0;
                        r_valid <= 1'b1;
                        r_state <= HOLD;
                    end else if (r_cnt == TC) begin
                        r_q     <= '0;
                        r_err   <= 1'b1;
                        r_valid <= 1'b1;
                        r_state <= HOLD;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.core_a     = r_a;
    assign bus.core_b     = r_b;
    assign bus.core_start = r_start;
    assign bus.out_valid  = r_valid;
    assign bus.out_q      = r_q;
    assign bus.out_a      = r_a;
    assign bus.out_b      = r_b;
    assign bus.out_err    = r_err;
    assign bus.busy       = r_busy;
endmodule
